// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX-stage pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              ready;
    logic              cancel;
    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] hi_cur;
    logic [DATA_W-1:0] lo_cur;
    logic              busy;
    logic [DATA_W-1:0] hi_wdata;
    logic [DATA_W-1:0] lo_wdata;
    logic              hi_we;
    logic              lo_we;

    modport master (
        output ready, cancel, start, op, src_a, src_b, hi_cur, lo_cur,
        input  busy, hi_wdata, lo_wdata, hi_we, lo_we
    );

    modport slave (
        input  ready, cancel, start, op, src_a, src_b, hi_cur, lo_cur,
        output busy, hi_wdata, lo_wdata, hi_we, lo_we
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO write data and enables.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_unit (
    input  logic         clock,
    input  logic         reset,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                sgn_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                op_legal_c;
    logic                op_div_c;
    logic                op_sgn_c;
    logic                a_neg_c;
    logic                b_neg_c;
    logic [DATA_W-1:0]   a_mag_c;
    logic [DATA_W-1:0]   b_mag_c;
    logic [2*DATA_W-1:0] ma_c;
    logic [2*DATA_W-1:0] mb_c;
    logic [2*DATA_W-1:0] prod_c;
    logic [2*DATA_W-1:0] mul_res_c;
    logic [DATA_W:0]     rem_shift_c;
    logic [DATA_W-1:0]   rem_sub_c;
    logic                rem_ge_c;
    logic [DATA_W-1:0]   quo_fix_c;
    logic [DATA_W-1:0]   rem_fix_c;
    logic                done_c;

`ifdef MULDIV_MADD_EN
    logic [2*DATA_W-1:0] acc_q;
    logic                acc_en_q;
    logic                acc_sub_q;

    assign op_legal_c = 1'b1;
`else
    logic unused_cur_c;

    assign op_legal_c   = ~mdu.op[2];
    assign unused_cur_c = ^{mdu.hi_cur, mdu.lo_cur};
`endif

    // Operand decode and magnitudes for the divider
    assign op_div_c = (mdu.op[2:1] == 2'b01);
    assign op_sgn_c = ~mdu.op[0];
    assign a_neg_c  = op_sgn_c & mdu.src_a[DATA_W-1];
    assign b_neg_c  = op_sgn_c & mdu.src_b[DATA_W-1];
    assign a_mag_c  = a_neg_c ? DATA_W'(-mdu.src_a) : mdu.src_a;
    assign b_mag_c  = b_neg_c ? DATA_W'(-mdu.src_b) : mdu.src_b;

    // Low 64 bits of a 64x64 product are the same for signed and unsigned once operands are extended
    assign ma_c   = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign mb_c   = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod_c = ma_c * mb_c;

    always_comb begin
        mul_res_c = prod_c;
`ifdef MULDIV_MADD_EN
        if (acc_en_q) begin
            mul_res_c = acc_sub_q ? (acc_q - prod_c) : (acc_q + prod_c);
        end
`endif
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits
    assign rem_shift_c = {rem_q, quo_q[DATA_W-1]};
    assign rem_ge_c    = (rem_shift_c >= {1'b0, b_q});
    assign rem_sub_c   = rem_shift_c[DATA_W-1:0] - b_q;

    assign quo_fix_c = q_neg_q ? DATA_W'(-quo_q) : quo_q;
    assign rem_fix_c = r_neg_q ? DATA_W'(-rem_q) : rem_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_MADD_EN
            acc_q     <= '0;
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
`endif
        end else if (mdu.cancel) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu.start && op_legal_c) begin
                        a_q   <= mdu.src_a;
                        sgn_q <= op_sgn_c;
                        if (op_div_c) begin
                            b_q     <= b_mag_c;
                            quo_q   <= a_mag_c;
                            rem_q   <= '0;
                            q_neg_q <= a_neg_c ^ b_neg_c;
                            r_neg_q <= a_neg_c;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end else begin
                            b_q     <= mdu.src_b;
`ifdef MULDIV_MADD_EN
                            acc_q     <= {mdu.hi_cur, mdu.lo_cur};
                            acc_en_q  <= mdu.op[2];
                            acc_sub_q <= mdu.op[1];
`endif
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    hi_q    <= mul_res_c[2*DATA_W-1:DATA_W];
                    lo_q    <= mul_res_c[DATA_W-1:0];
                    state_q <= S_DONE;
                end
                S_DIV: begin
                    if (cnt_q == CNT_W'(DIV_ITER)) begin
                        // Sign-fix cycle; a zero divisor returns all-ones quotient and the raw dividend
                        if (b_q == '0) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix_c;
                            lo_q <= quo_fix_c;
                        end
                        state_q <= S_DONE;
                    end else begin
                        rem_q <= rem_ge_c ? rem_sub_c : rem_shift_c[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], rem_ge_c};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (mdu.ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done_c = (state_q == S_DONE) & mdu.ready & ~mdu.cancel;

    assign mdu.busy     = (state_q == S_MUL) | (state_q == S_DIV) |
                          ((state_q == S_IDLE) & mdu.start & op_legal_c);
    assign mdu.hi_wdata = hi_q;
    assign mdu.lo_wdata = lo_q;
    assign mdu.hi_we    = done_c;
    assign mdu.lo_we    = done_c;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_muldiv_unit;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    muldiv_unit_if mdu ();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .mdu   (mdu)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hc;
        logic [31:0] lc;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          elat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference results from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hc, input logic [31:0] lc);
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        int          sa;
        int          sb;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        acc = {hc, lc};
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            3'd0: return 64'(sp);
            3'd1: return up;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return acc + 64'(sp);
            3'd5: return acc + up;
            3'd6: return acc - 64'(sp);
            default: return acc - up;
        endcase
    endfunction

    // Issue one op at cycle T and report busy at T, the cycle offset of the write and its data
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hc, input logic [31:0] lc, input int budget,
                          output logic busy0, output logic [31:0] hi, output logic [31:0] lo, output int lat);
        @(negedge clock);
        mdu.op     = op;
        mdu.src_a  = a;
        mdu.src_b  = b;
        mdu.hi_cur = hc;
        mdu.lo_cur = lc;
        mdu.start  = 1'b1;
        #1 busy0 = mdu.busy;
        @(negedge clock);
        mdu.start = 1'b0;
        lat = -1;
        hi  = '0;
        lo  = '0;
        for (int k = 1; k <= budget; k++) begin
            if (mdu.hi_we || mdu.lo_we) begin
                chk("we_pair", 64'({mdu.hi_we, mdu.lo_we}), 64'd3);
                lat = k;
                hi  = mdu.hi_wdata;
                lo  = mdu.lo_wdata;
                break;
            end
            @(negedge clock);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 20));
            1: return 32'(-int'($urandom_range(0, 20)));
            2: begin
                case ($urandom_range(0, 2))
                    0: return 32'h0;
                    1: return 32'h8000_0000;
                    default: return 32'hFFFF_FFFF;
                endcase
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vq[$];
        logic        busy0;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] save_hi;
        logic [31:0] save_lo;
        logic [63:0] exp;
        int          lat;
        int          we_cnt;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rhc;
        logic [31:0] rlc;

        tests = 0;
        fails = 0;
        reset      = 1'b0;
        mdu.ready  = 1'b1;
        mdu.cancel = 1'b0;
        mdu.start  = 1'b0;
        mdu.op     = '0;
        mdu.src_a  = '0;
        mdu.src_b  = '0;
        mdu.hi_cur = '0;
        mdu.lo_cur = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_busy", 64'(mdu.busy), 64'd0);
        chk("rst_we", 64'({mdu.hi_we, mdu.lo_we}), 64'd0);
        chk("rst_wdata", {mdu.hi_wdata, mdu.lo_wdata}, 64'd0);

        // Directed table
        vq.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7,         32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2});
        vq.push_back('{3'd3, 32'd100,       32'd7,         32'd0, 32'd0, 32'd2,         32'd14,        34});
        vq.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34});
        vq.push_back('{3'd2, 32'h0000_1234, 32'd0,         32'd0, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 34});
        vq.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,         32'h8000_0000, 34});
        vq.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001, 2});
        vq.push_back('{3'd3, 32'h0000_0010, 32'd0,         32'd0, 32'd0, 32'h0000_0010, 32'hFFFF_FFFF, 34});
        vq.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1,         32'hFFFF_FFFD, 34});
        vq.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'h4000_0000, 32'd0,         2});
        vq.push_back('{3'd2, 32'hFFFF_FFF8, 32'd0,         32'd0, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 34});
`ifdef MULDIV_MADD_EN
        vq.push_back('{3'd5, 32'd1,         32'd1,         32'd0, 32'hFFFF_FFFF, 32'd1,     32'd0,         2});
        vq.push_back('{3'd6, 32'd2,         32'd3,         32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2});
`else
        vq.push_back('{3'd5, 32'd1,         32'd1,         32'd0, 32'hFFFF_FFFF, 32'd0,     32'd0,         -1});
        vq.push_back('{3'd6, 32'd2,         32'd3,         32'd0, 32'd0, 32'd0,         32'd0,         -1});
`endif
        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, vq[i].hc, vq[i].lc, 40, busy0, hi, lo, lat);
            chk($sformatf("vec%0d_busy", i), 64'(busy0), 64'(vq[i].elat > 0));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vq[i].elat));
            if (vq[i].elat > 0) begin
                chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vq[i].ehi, vq[i].elo});
            end
        end

        // MULTU held in DONE by ready=0 for cycles T+2..T+5
        @(negedge clock);
        mdu.op = 3'd1; mdu.src_a = 32'hFFFF_FFFF; mdu.src_b = 32'hFFFF_FFFF; mdu.start = 1'b1;
        @(negedge clock);
        mdu.start = 1'b0;
        mdu.ready = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            chk($sformatf("stall_we_t%0d", k), 64'({mdu.hi_we, mdu.lo_we}), 64'd0);
        end
        @(posedge clock);
        #1 mdu.ready = 1'b1;
        @(negedge clock);
        chk("stall_release_we", 64'({mdu.hi_we, mdu.lo_we}), 64'd3);
        chk("stall_release_hilo", {mdu.hi_wdata, mdu.lo_wdata}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clock);
        chk("stall_single_pulse", 64'({mdu.hi_we, mdu.lo_we}), 64'd0);
        save_hi = 32'hFFFF_FFFE;
        save_lo = 32'h0000_0001;

        // DIVU cancelled at T+10: no write, outputs keep the previous result
        @(negedge clock);
        mdu.op = 3'd3; mdu.src_a = 32'd1000; mdu.src_b = 32'd3; mdu.start = 1'b1;
        @(negedge clock);
        mdu.start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clock);
        mdu.cancel = 1'b1;
        @(negedge clock);
        mdu.cancel = 1'b0;
        chk("cancel_busy", 64'(mdu.busy), 64'd0);
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (mdu.hi_we || mdu.lo_we) we_cnt++;
            @(negedge clock);
        end
        chk("cancel_no_we", 64'(we_cnt), 64'd0);
        chk("cancel_persist", {mdu.hi_wdata, mdu.lo_wdata}, {save_hi, save_lo});
        run_op(3'd0, 32'd5, 32'd6, 32'd0, 32'd0, 40, busy0, hi, lo, lat);
        chk("post_cancel_lat", 64'(lat), 64'd2);
        chk("post_cancel_hilo", {hi, lo}, 64'd30);

        // Cancel arriving in DONE suppresses the write
        @(negedge clock);
        mdu.op = 3'd0; mdu.src_a = 32'd2; mdu.src_b = 32'd3; mdu.start = 1'b1;
        @(negedge clock);
        mdu.start = 1'b0;
        @(posedge clock);
        #1 mdu.cancel = 1'b1;
        #1 chk("done_cancel_we", 64'({mdu.hi_we, mdu.lo_we}), 64'd0);
        @(posedge clock);
        #1 mdu.cancel = 1'b0;
        @(negedge clock);
        chk("done_cancel_idle", 64'({mdu.busy, mdu.hi_we, mdu.lo_we}), 64'd0);

        // Reset in the middle of a divide
        @(negedge clock);
        mdu.op = 3'd2; mdu.src_a = 32'd77; mdu.src_b = 32'd5; mdu.start = 1'b1;
        @(negedge clock);
        mdu.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("midrst_busy", 64'(mdu.busy), 64'd0);
        chk("midrst_wdata", {mdu.hi_wdata, mdu.lo_wdata}, 64'd0);
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (mdu.hi_we || mdu.lo_we) we_cnt++;
            @(negedge clock);
        end
        chk("midrst_no_we", 64'(we_cnt), 64'd0);

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
`ifdef MULDIV_MADD_EN
            rop = 3'($urandom_range(0, 7));
`else
            rop = 3'($urandom_range(0, 3));
`endif
            ra  = pick();
            rb  = pick();
            rhc = $urandom;
            rlc = $urandom;
            exp = model(rop, ra, rb, rhc, rlc);
            run_op(rop, ra, rb, rhc, rlc, 40, busy0, hi, lo, lat);
            chk($sformatf("rnd%0d_op%0d_lat", i, rop), 64'(lat), (rop[2:1] == 2'b01) ? 64'd34 : 64'd2);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), {hi, lo}, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
